// File: rtl/p18_ball_motion_if.sv
// Ball-motion bus: frame timing and collision inputs in, registered ball
// position, direction, event pulses and FSM state out.
interface p18_ball_motion_if;
    logic       frame_pulse;
    logic       in_ball_top;
    logic       in_ball_bottom;
    logic       in_ball_left;
    logic       in_ball_right;
    logic       obstacle;
    logic       serve;
    logic [9:0] x;
    logic [8:0] y;
    logic       dir_x;
    logic       dir_y;
    logic       hit;
    logic       lost;
    logic [1:0] state;

    // Handshake: no valid/ready pair. frame_pulse and serve are single-cycle
    // strobes sampled on the rising edge; every output is registered and
    // reflects an accepted strobe one cycle later. hit/lost are single-cycle.
    modport master (
        output frame_pulse, in_ball_top, in_ball_bottom, in_ball_left,
               in_ball_right, obstacle, serve,
        input  x, y, dir_x, dir_y, hit, lost, state
    );

    modport slave (
        input  frame_pulse, in_ball_top, in_ball_bottom, in_ball_left,
               in_ball_right, obstacle, serve,
        output x, y, dir_x, dir_y, hit, lost, state
    );
endinterface

// File: rtl/p18_ball_motion.sv
// Ball motion engine: collects collision flags during a frame and, on each
// frame_pulse, resolves bounces and steps the ball by STEP pixels per axis.
module p18_ball_motion #(
    parameter int START_X = 318,
    parameter int START_Y = 240,
    parameter int STEP    = 2,
    parameter int X_MAX   = 635,
    parameter int Y_MAX   = 475
) (
    input  logic               clk,
    input  logic               nRst,
    p18_ball_motion_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        LOST = 2'd2
    } state_t;

    localparam logic [9:0]  START_X_C = 10'(START_X);
    localparam logic [8:0]  START_Y_C = 9'(START_Y);
    localparam logic [9:0]  X_MAX_C   = 10'(X_MAX);
    localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
    localparam logic [9:0]  Y_MAX_W   = 10'(Y_MAX);
    localparam logic [10:0] STEP_X    = 11'(STEP);
    localparam logic [9:0]  STEP_Y    = 10'(STEP);

    state_t     state;
    logic [9:0] x_q;
    logic [8:0] y_q;
    logic       dir_x_q;
    logic       dir_y_q;
    logic       hit_q;
    logic       lost_q;
    // flags: [3]=top [2]=bottom [1]=left [0]=right
    logic [3:0] flags;

    logic [3:0]  hit_now;
    logic        dx_res;
    logic        dy_res;
    logic [10:0] x_wide;
    logic [9:0]  y_wide;
    logic [9:0]  nx;
    logic [8:0]  ny;
    logic        ndx;
    logic        ndy;
    logic        out_bottom;

    assign hit_now = {bus.in_ball_top, bus.in_ball_bottom,
                      bus.in_ball_left, bus.in_ball_right} & {4{bus.obstacle}};

    // Frame resolution: direction from flags first, then step with edge clamps.
    always_comb begin
        dx_res     = dir_x_q;
        dy_res     = dir_y_q;
        x_wide     = {1'b0, x_q};
        y_wide     = {1'b0, y_q};
        nx         = x_q;
        ny         = y_q;
        out_bottom = 1'b0;

        if (flags[3] && !flags[2]) dy_res = 1'b1;
        else if (flags[2] && !flags[3]) dy_res = 1'b0;
        if (flags[1] && !flags[0]) dx_res = 1'b1;
        else if (flags[0] && !flags[1]) dx_res = 1'b0;

        ndx = dx_res;
        ndy = dy_res;

        if (dx_res) begin
            if (x_wide + STEP_X > X_MAX_W) begin
                nx  = X_MAX_C;
                ndx = 1'b0;
            end else begin
                nx = 10'(x_wide + STEP_X);
            end
        end else begin
            if (x_wide < STEP_X) begin
                nx  = 10'd0;
                ndx = 1'b1;
            end else begin
                nx = 10'(x_wide - STEP_X);
            end
        end

        if (dy_res) begin
            if (y_wide + STEP_Y > Y_MAX_W) begin
                out_bottom = 1'b1;
            end else begin
                ny = 9'(y_wide + STEP_Y);
            end
        end else begin
            if (y_wide < STEP_Y) begin
                ny  = 9'd0;
                ndy = 1'b1;
            end else begin
                ny = 9'(y_wide - STEP_Y);
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state   <= IDLE;
            x_q     <= START_X_C;
            y_q     <= START_Y_C;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b0;
            hit_q   <= 1'b0;
            lost_q  <= 1'b0;
            flags   <= 4'b0000;
        end else begin
            hit_q  <= 1'b0;
            lost_q <= 1'b0;
            case (state)
                IDLE: begin
                    flags <= 4'b0000;
                    if (bus.serve) state <= PLAY;
                end
                PLAY: begin
                    if (bus.frame_pulse) begin
                        flags <= 4'b0000;
                        // Falling out the bottom freezes the ball where it is.
                        if (out_bottom) begin
                            lost_q <= 1'b1;
                            state  <= LOST;
                        end else begin
                            x_q     <= nx;
                            y_q     <= ny;
                            dir_x_q <= ndx;
                            dir_y_q <= ndy;
                            hit_q   <= |flags;
                        end
                    end else begin
                        flags <= flags | hit_now;
                    end
                end
                LOST: begin
                    flags <= 4'b0000;
                    if (bus.frame_pulse) begin
                        state   <= IDLE;
                        x_q     <= START_X_C;
                        y_q     <= START_Y_C;
                        dir_x_q <= 1'b1;
                        dir_y_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    flags <= 4'b0000;
                end
            endcase
        end
    end

    assign bus.x     = x_q;
    assign bus.y     = y_q;
    assign bus.dir_x = dir_x_q;
    assign bus.dir_y = dir_y_q;
    assign bus.hit   = hit_q;
    assign bus.lost  = lost_q;
    assign bus.state = state;

endmodule

// File: tb/tb_p18_ball_motion.sv
// Bench for p18_ball_motion: integer reference model predicts each frame/serve
// outcome into a queue; a negedge monitor pops and compares.
module tb_p18_ball_motion;

    localparam int START_X = 318;
    localparam int START_Y = 240;
    localparam int STEP    = 2;
    localparam int X_MAX   = 635;
    localparam int Y_MAX   = 475;
    localparam int S_IDLE  = 0;
    localparam int S_PLAY  = 1;
    localparam int S_LOST  = 2;
    localparam int W       = 25;

    logic clk;
    logic nRst;
    p18_ball_motion_if bus ();

    p18_ball_motion #(
        .START_X(START_X), .START_Y(START_Y), .STEP(STEP),
        .X_MAX(X_MAX), .Y_MAX(Y_MAX)
    ) dut (
        .clk (clk),
        .nRst(nRst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int  tests = 0;
    int  fails = 0;
    bit  done = 0;
    bit  done_seen = 0;
    logic ev_d;

    // reference model
    int m_x, m_y, m_state;
    bit m_dx, m_dy;
    bit f_top, f_bot, f_left, f_right;

    function automatic logic [W-1:0] pack(int px, int py, bit dx, bit dy,
                                          bit h, bit l, int st);
        logic [W-1:0] v;
        v = {10'(px), 9'(py), dx, dy, h, l, 2'(st)};
        return v;
    endfunction

    task automatic model_reset();
        m_x = START_X; m_y = START_Y; m_dx = 1; m_dy = 0; m_state = S_IDLE;
        f_top = 0; f_bot = 0; f_left = 0; f_right = 0;
    endtask

    task automatic model_step(input bit fp, input bit sv, input bit t,
                              input bit b, input bit l, input bit r, input bit ob);
        bit h = 0;
        bit lo = 0;
        int nx, ny;
        bit ndx, ndy;
        if (m_state == S_PLAY && !fp) begin
            f_top |= t & ob; f_bot |= b & ob; f_left |= l & ob; f_right |= r & ob;
        end
        if (m_state == S_IDLE) begin
            if (sv) m_state = S_PLAY;
        end else if (m_state == S_PLAY) begin
            if (fp) begin
                ndx = m_dx; ndy = m_dy;
                if (f_top != f_bot) ndy = f_top;
                if (f_left != f_right) ndx = f_left;
                nx = m_x + (ndx ? STEP : -STEP);
                ny = m_y + (ndy ? STEP : -STEP);
                if (nx < 0) begin nx = 0; ndx = 1; end
                else if (nx > X_MAX) begin nx = X_MAX; ndx = 0; end
                if (ny < 0) begin ny = 0; ndy = 1; end
                if (ny > Y_MAX) begin
                    lo = 1;
                    m_state = S_LOST;
                end else begin
                    h = f_top | f_bot | f_left | f_right;
                    m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
                end
            end
        end else begin
            if (fp) begin
                m_x = START_X; m_y = START_Y; m_dx = 1; m_dy = 0; m_state = S_IDLE;
            end
        end
        if (fp) begin
            f_top = 0; f_bot = 0; f_left = 0; f_right = 0;
        end
        if (fp || sv) exp_q.push_back(pack(m_x, m_y, m_dx, m_dy, h, lo, m_state));
    endtask

    // driver tasks
    task automatic drive(input bit fp, input bit sv, input bit t, input bit b,
                         input bit l, input bit r, input bit ob);
        bus.frame_pulse = fp; bus.serve = sv; bus.obstacle = ob;
        bus.in_ball_top = t; bus.in_ball_bottom = b;
        bus.in_ball_left = l; bus.in_ball_right = r;
        model_step(fp, sv, t, b, l, r, ob);
        @(posedge clk); #1;
        bus.frame_pulse = 0; bus.serve = 0; bus.obstacle = 0;
        bus.in_ball_top = 0; bus.in_ball_bottom = 0;
        bus.in_ball_left = 0; bus.in_ball_right = 0;
    endtask

    task automatic frame();
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk); #1;
        nRst = 0;
        model_reset();
        @(negedge clk);
        @(posedge clk); #1;
        nRst = 1;
    endtask

    always @(posedge clk or negedge nRst) begin
        if (!nRst) ev_d <= 1'b0;
        else ev_d <= bus.frame_pulse | bus.serve;
    end

    // monitor
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] exp_v;
        act = {bus.x, bus.y, bus.dir_x, bus.dir_y, bus.hit, bus.lost, bus.state};
        if (!nRst) begin
            exp_v = pack(START_X, START_Y, 1, 0, 0, 0, S_IDLE);
            tests++;
            if (act !== exp_v) begin
                fails++;
                $display("FAIL reset_values got=%h exp=%h", act, exp_v);
            end
        end else begin
            if (ev_d) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL event_underflow got=%h exp=none", act);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (act !== exp_v) begin
                        fails++;
                        $display("FAIL frame_event got x=%0d y=%0d dx=%0b dy=%0b hit=%0b lost=%0b st=%0d exp x=%0d y=%0d dx=%0b dy=%0b hit=%0b lost=%0b st=%0d",
                                 act[24:15], act[14:6], act[5], act[4], act[3], act[2], act[1:0],
                                 exp_v[24:15], exp_v[14:6], exp_v[5], exp_v[4], exp_v[3], exp_v[2], exp_v[1:0]);
                    end
                end
            end else begin
                tests++;
                if (bus.hit !== 1'b0 || bus.lost !== 1'b0) begin
                    fails++;
                    $display("FAIL stray_pulse got hit=%b lost=%b exp hit=0 lost=0", bus.hit, bus.lost);
                end
            end
            if (done && !done_seen) begin
                done_seen = 1;
                tests++;
                if (exp_q.size() != 0) begin
                    fails++;
                    $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
                end
            end
        end
    end

    initial begin
        nRst = 0;
        bus.frame_pulse = 0; bus.serve = 0; bus.obstacle = 0;
        bus.in_ball_top = 0; bus.in_ball_bottom = 0;
        bus.in_ball_left = 0; bus.in_ball_right = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1;
        nRst = 1;

        // IDLE ignores frames
        frame(); frame();
        // serve then two frames: 320/238, 322/236
        drive(0, 1, 0, 0, 0, 0, 0);
        frame(); frame();
        // top collision turns the ball downward with a hit
        drive(0, 0, 1, 0, 0, 0, 1);
        frame();
        // left and right together: direction kept, still a hit
        drive(0, 0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 1);
        frame();
        // collision region without obstacle sets nothing
        drive(0, 0, 1, 1, 1, 1, 0);
        frame();
        // serve ignored while playing
        drive(0, 1, 0, 0, 0, 0, 0);
        // reset with flags pending, then a frame gives no motion or hit
        drive(0, 0, 1, 0, 0, 0, 1);
        pulse_reset();
        frame();

        // free flight: top bounce, right-edge clamp, fall out, LOST -> IDLE
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 420; i++) frame();
        frame(); frame();

        // randomized play
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                pulse_reset();
            end else begin
                drive($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 9) == 0);
            end
        end

        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        done = 1;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
